rr_onehot_arbiter: RTL and testbench
====================================

# rr_onehot_arbiter

Round-robin arbiter that produces the registered one-hot select consumed by the team's one-hot multiplexers. It picks one of `REQ_NUM` requesters, drives a one-hot grant plus its binary index, and holds the grant under a valid/ready handshake with the downstream consumer. An optional lock keeps the grant on one requester across consecutive transfers. It sits in front of any shared resource whose datapath is steered by a one-hot mux, such as a CDB slot, a functional-unit result port or a free-list read port.

## Interface
- `REQ_NUM`, 16, number of requesters; legal range 2 and up, power of two not required.
- `IDX_W`, `$clog2(REQ_NUM)`, width of the binary grant index; derived, do not override.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  REQ_NUM  per-requester request; bit i high means requester i wants the resource.
- `lock`  input  1  sampled on a handshake cycle; high means keep the current grant for the next transfer.
- `ready`  input  1  downstream accepts the granted transfer this cycle.
- `grant`  output  REQ_NUM  registered one-hot grant; all-zero when there is no grant.
- `grant_valid`  output  1  registered; high exactly when `grant` is non-zero.
- `grant_idx`  output  IDX_W  registered binary index of the granted bit; 0 when there is no grant.

## Operation
- **State.**
  - Priority pointer `ptr` holds values 0..REQ_NUM-1.
  - FSM has three states: IDLE, GRANT and LOCKED.
  - Output registers are `grant`, `grant_valid` and `grant_idx`.
- **Pick function** (combinational).
  - Selects the first set bit of `req` scanning from `ptr` upward, wrapping from REQ_NUM-1 to 0.
  - No set bit means no pick.
- **IDLE**
  - Outputs are all zero.
  - If any `req` bit is set, register the pick and go to GRANT.
- **GRANT**
  - Outputs are held stable until a handshake (`grant_valid & ready`).
  - Handshake with `lock`=1 and `req[grant_idx]`=1:
    - Keep the grant, leave `ptr` unchanged and go to LOCKED.
  - Handshake otherwise:
    - Set `ptr` to `(grant_idx+1) mod REQ_NUM`.
    - Pick again from the current `req` with the granted bit masked off, using the new `ptr`.
    - If there is a pick, register it and stay in GRANT (back-to-back, no bubble). If not, go to IDLE.
  - No handshake and `req[grant_idx]` drops:
    - Withdraw the grant next cycle, go to IDLE and leave `ptr` unchanged.
- **LOCKED**
  - Same behaviour as GRANT.
  - Releasing the lock with `lock`=0 on a handshake follows the GRANT handshake rule and advances `ptr`.
- **Invariants.**
  - `grant` is always zero or exactly one-hot.
  - `grant_idx` always matches `grant`.
  - `grant` only ever points at a bit that was set in `req` on the cycle it was registered.
- **Reset**
  - Puts the FSM in IDLE and sets `ptr`=0, `grant`=0, `grant_valid`=0 and `grant_idx`=0.
  - Reset asserted mid-transfer clears the outputs immediately, without waiting for the clock.

## Timing
- From `req` rising in IDLE to `grant_valid` takes 1 cycle.
- On a handshake at edge N, the next grant is visible after edge N. Throughput is one grant per cycle while requests remain.
- `ready` while `grant_valid`=0 is ignored.
- `lock` is sampled only on handshake cycles.
- A requester dropping `req` on the same cycle as its handshake counts as a completed transfer: `ptr` advances and LOCKED is not entered.
- Fairness: with all requests continuously asserted and `lock`=0, each requester is granted once every REQ_NUM handshakes.
- Pointer wrap: a handshake on index REQ_NUM-1 sets `ptr` to 0. This holds for non-power-of-two REQ_NUM as well.

## Test plan
- **Reset, then single request.** REQ_NUM=4, `rst_n` low then high, `req`=4'b0100, `ready`=1.
  - Required: `grant`=0100, `grant_idx`=2 one cycle after `req`.
  - Required: after the handshake, `ptr`=3.
- **Full round-robin.** `req`=4'b1111, `ready`=1 held.
  - Required: grants in the order 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no bubbles.
- **Backpressure.** `req`=4'b0011, `ready`=0 for 5 cycles, then 1.
  - Required: `grant`=0001 held stable for all 5 cycles.
  - Required: 0010 on the cycle after `ready` rises.
- **Lock.** `req`=4'b0101, `lock`=1 for 3 handshakes, then 0.
  - Required: `grant`=0001 for all 3 transfers, then 0100.
- **Request withdrawal.** `grant`=0010 with `ready`=0, then `req[1]` drops.
  - Required: `grant_valid`=0 next cycle, and `ptr` unchanged.
  - Required: re-raising `req[1]` re-grants index 1.
- **Asynchronous reset mid-grant.** `grant`=1000, `rst_n` pulsed low between clock edges.
  - Required: outputs go to 0 immediately.
  - Required: after release with `req`=4'b1001, the first grant is 0001 (`ptr`=0).

Source files
------------

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between a set of requesters, the round-robin arbiter and the
// downstream consumer that steers a one-hot mux with the grant.
interface rr_onehot_arbiter_if #(
  parameter int unsigned REQ_NUM = 16
);
  localparam int unsigned IDX_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0] req;
  logic               lock;
  logic               ready;
  logic [REQ_NUM-1:0] grant;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;

  // Arbiter side: consumes requests and handshake, produces the grant.
  modport master (
    input  req,
    input  lock,
    input  ready,
    output grant,
    output grant_valid,
    output grant_idx
  );

  // Requester/consumer side.
  modport slave (
    output req,
    output lock,
    output ready,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, binary index and valid/ready
// handshake. An optional lock keeps the grant on one requester across transfers.
module rr_onehot_arbiter #(
  parameter int unsigned REQ_NUM = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_onehot_arbiter_if.master   bus
);
  localparam int unsigned IDX_W = $clog2(REQ_NUM);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StLocked
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [REQ_NUM-1:0] grant_q;
  logic               grant_valid_q;
  logic [IDX_W-1:0]   grant_idx_q;

  // First set bit of r scanning upward from p with wrap; MSB of result is the found flag.
  // Scanning from the farthest slot back toward p lets the nearest hit win without a flag.
  function automatic logic [IDX_W:0] pick(input logic [REQ_NUM-1:0] r,
                                          input logic [IDX_W-1:0]   p);
    logic [IDX_W:0] res;
    int             j;
    res = '0;
    for (int k = int'(REQ_NUM) - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= int'(REQ_NUM)) j = j - int'(REQ_NUM);
      if (r[j]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  function automatic logic [REQ_NUM-1:0] to_onehot(input logic [IDX_W-1:0] i);
    logic [REQ_NUM-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  logic             hs;
  logic             cur_req;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W:0]   idle_pick;
  logic [IDX_W:0]   next_pick;

  // Handshake detection and the two candidate picks (from idle, and after a transfer).
  always_comb begin
    hs        = grant_valid_q & bus.ready;
    cur_req   = bus.req[grant_idx_q];
    ptr_inc   = (grant_idx_q == IDX_W'(REQ_NUM - 1)) ? '0 : grant_idx_q + 1'b1;
    idle_pick = pick(bus.req, ptr_q);
    next_pick = pick(bus.req & ~grant_q, ptr_inc);
  end

  // FSM, priority pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (idle_pick[IDX_W]) begin
            grant_q       <= to_onehot(idle_pick[IDX_W-1:0]);
            grant_valid_q <= 1'b1;
            grant_idx_q   <= idle_pick[IDX_W-1:0];
            state_q       <= StGrant;
          end
        end
        StGrant, StLocked: begin
          if (hs) begin
            if (bus.lock && cur_req) begin
              // Hold the grant; pointer stays put while locked.
              state_q <= StLocked;
            end else begin
              ptr_q <= ptr_inc;
              if (next_pick[IDX_W]) begin
                grant_q       <= to_onehot(next_pick[IDX_W-1:0]);
                grant_valid_q <= 1'b1;
                grant_idx_q   <= next_pick[IDX_W-1:0];
                state_q       <= StGrant;
              end else begin
                grant_q       <= '0;
                grant_valid_q <= 1'b0;
                grant_idx_q   <= '0;
                state_q       <= StIdle;
              end
            end
          end else if (!cur_req) begin
            // Requester withdrew before the transfer: drop the grant, keep the pointer.
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed scoreboard bench for rr_onehot_arbiter with four requesters.
module tb_rr_onehot_arbiter;
  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;

  rr_onehot_arbiter_if #(.REQ_NUM(N)) bus ();

  rr_onehot_arbiter #(.REQ_NUM(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [N-1:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [N-1:0] g);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < int'(N); i++) if (g[i]) r = i;
    return r;
  endfunction

  // Monitor: one expected grant per cycle, compared away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("grant", 32'(bus.grant), 32'(e));
      check_eq("grant_valid", 32'(bus.grant_valid), 32'(|e));
      check_eq("grant_idx", 32'(bus.grant_idx), idx_of(e));
    end
  end

  // Drive one cycle of inputs and queue the grant expected after the next edge.
  task automatic step(input logic [N-1:0] r, input logic l, input logic rd,
                      input logic [N-1:0] e);
    bus.req   = r;
    bus.lock  = l;
    bus.ready = rd;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.lock  = 1'b0;
    bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_grant", 32'(bus.grant), 32'h0);
    check_eq("rst_valid", 32'(bus.grant_valid), 32'h0);
    check_eq("rst_idx", 32'(bus.grant_idx), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, then prove ptr=3 via 1100 picking index 3.
    step(4'b0100, 1'b0, 1'b1, 4'b0100);
    step(4'b0000, 1'b0, 1'b1, 4'b0000);
    step(4'b1100, 1'b0, 1'b0, 4'b1000);
    step(4'b1100, 1'b0, 1'b1, 4'b0100);
    step(4'b0000, 1'b0, 1'b1, 4'b0000);

    // Full round-robin from ptr=3, including wrap back to 0; withdraw leaves ptr=0.
    step(4'b1111, 1'b0, 1'b1, 4'b1000);
    step(4'b1111, 1'b0, 1'b1, 4'b0001);
    step(4'b1111, 1'b0, 1'b1, 4'b0010);
    step(4'b1111, 1'b0, 1'b1, 4'b0100);
    step(4'b1111, 1'b0, 1'b1, 4'b1000);
    step(4'b1111, 1'b0, 1'b1, 4'b0001);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Backpressure: 0001 held five cycles, then 0010 after ready rises.
    step(4'b0011, 1'b0, 1'b0, 4'b0001);
    for (int i = 0; i < 5; i++) step(4'b0011, 1'b0, 1'b0, 4'b0001);
    step(4'b0011, 1'b0, 1'b1, 4'b0010);
    step(4'b0011, 1'b0, 1'b1, 4'b0001);

    // Lock on requester 0 for three handshakes, then release to 0100.
    for (int i = 0; i < 3; i++) step(4'b0101, 1'b1, 1'b1, 4'b0001);
    step(4'b0101, 1'b0, 1'b1, 4'b0100);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Withdrawal of req[1] under backpressure; ptr must stay at 1.
    step(4'b0010, 1'b0, 1'b0, 4'b0010);
    step(4'b0010, 1'b0, 1'b0, 4'b0010);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);
    step(4'b0011, 1'b0, 1'b0, 4'b0010);
    step(4'b0000, 1'b0, 1'b0, 4'b0000);

    // Asynchronous reset while 1000 is granted.
    step(4'b1000, 1'b0, 1'b0, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_grant", 32'(bus.grant), 32'h0);
    check_eq("async_valid", 32'(bus.grant_valid), 32'h0);
    check_eq("async_idx", 32'(bus.grant_idx), 32'h0);
    bus.req = '0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    step(4'b1001, 1'b0, 1'b0, 4'b0001);
    step(4'b1001, 1'b0, 1'b1, 4'b1000);
    step(4'b0000, 1'b0, 1'b1, 4'b0000);

    budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) check_eq("drain", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
